// File: rtl/t07_pixel_scanner.sv
`timescale 1ns/1ps
// Row-major raster scanner: presents x/y to the pixel generators, latches their
// registered 1-bit result and streams RGB565 pixels over a valid/ready handshake.
module t07_pixel_scanner #(
    parameter int unsigned H_PIXELS = 320,
    parameter int unsigned V_PIXELS = 240,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic        pixel_in,
    input  logic        ready,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned X_W = 9;
    localparam int unsigned Y_W = 8;
    localparam int unsigned D_W = 16;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_SEND,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [D_W-1:0] data_q, data_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= BG_COLOR;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; frame_done is a single-cycle pulse
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                data_d  = pixel_in ? FG_COLOR : BG_COLOR;
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (ready) begin
                    valid_d = 1'b0;
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        x_d     = '0;
                        y_d     = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else if (x_q == X_LAST) begin
                        x_d     = '0;
                        y_d     = y_q + Y_W'(1);
                        state_d = S_ADDR;
                    end else begin
                        x_d     = x_q + X_W'(1);
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_data  = data_q;
    assign pixel_valid = valid_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_t07_pixel_scanner.sv
`timescale 1ns/1ps
// Directed bench for t07_pixel_scanner on a 4x3 frame with a registered
// pixel generator model that lights a single column.
module tb_t07_pixel_scanner;

    localparam int unsigned H = 4;
    localparam int unsigned V = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        pixel_in;
    logic        ready;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        busy;
    logic        frame_done;

    logic [8:0]  gen_x;
    int          tests_run    = 0;
    int          tests_failed = 0;

    t07_pixel_scanner #(
        .H_PIXELS (H),
        .V_PIXELS (V),
        .FG_COLOR (16'hFFFF),
        .BG_COLOR (16'h0000)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .pixel_in    (pixel_in),
        .ready       (ready),
        .x           (x),
        .y           (y),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Registered generator: lit only in column gen_x, one cycle behind x/y
    always @(posedge clk) pixel_in <= (x == gen_x);

    task automatic test_reset;
        nrst  = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        gen_x = 9'd2;
        #12;
        tests_run++;
        if ({x, y, pixel_data, pixel_valid, busy, frame_done} !== {9'd0, 8'd0, 16'h0000, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_values: got x=%0d y=%0d d=%h v=%b b=%b fd=%b, expected all zero",
                     x, y, pixel_data, pixel_valid, busy, frame_done);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({pixel_valid, busy, frame_done} !== 3'b000) begin
                tests_failed++;
                $display("FAIL idle_hold: got v=%b b=%b fd=%b, expected 000", pixel_valid, busy, frame_done);
            end
        end
    endtask

    task automatic test_small_frame;
        int n;
        int done_e;
        int pulses;
        logic busy_at_done;
        n = 0; done_e = -1; pulses = 0; busy_at_done = 1'b1;
        gen_x = 9'd2;
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if ({busy, x, y} !== {1'b1, 9'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL frame_start: got b=%b x=%0d y=%0d, expected b=1 x=0 y=0", busy, x, y);
        end
        for (int e = 1; e <= 45; e++) begin
            if (pixel_valid && ready) begin
                tests_run++;
                if ({x, y, pixel_data} !== {9'(n % H), 8'(n / H), ((n % H) == 2) ? 16'hFFFF : 16'h0000}) begin
                    tests_failed++;
                    $display("FAIL small_xfer%0d: got x=%0d y=%0d d=%h, expected x=%0d y=%0d", n, x, y,
                             pixel_data, n % H, n / H);
                end
                n++;
            end
            @(posedge clk); #1;
            if (frame_done) begin
                pulses++;
                if (done_e < 0) begin
                    done_e       = e;
                    busy_at_done = busy;
                end
            end
        end
        tests_run++;
        if (n != 12) begin
            tests_failed++;
            $display("FAIL small_count: got %0d transfers, expected 12", n);
        end
        tests_run++;
        if (done_e != 36) begin
            tests_failed++;
            $display("FAIL small_done_time: got edge %0d, expected 36", done_e);
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL small_done_pulse: got %0d cycles high, expected 1", pulses);
        end
        tests_run++;
        if (busy_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL small_busy_fall: got busy=%b at frame_done, expected 0", busy_at_done);
        end
    endtask

    task automatic test_backpressure;
        int n;
        int pulses;
        logic stalled;
        n = 0; pulses = 0; stalled = 1'b0;
        gen_x = 9'd1;
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            if (!stalled && pixel_valid && x == 9'd1 && y == 8'd1) begin
                ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    tests_run++;
                    if ({pixel_valid, pixel_data, x, y} !== {1'b1, 16'hFFFF, 9'd1, 8'd1}) begin
                        tests_failed++;
                        $display("FAIL stall_hold%0d: got v=%b d=%h x=%0d y=%0d, expected v=1 d=ffff x=1 y=1",
                                 k, pixel_valid, pixel_data, x, y);
                    end
                end
                ready   = 1'b1;
                stalled = 1'b1;
            end
            if (pixel_valid && ready) begin
                tests_run++;
                if ({x, y, pixel_data} !== {9'(n % H), 8'(n / H), ((n % H) == 1) ? 16'hFFFF : 16'h0000}) begin
                    tests_failed++;
                    $display("FAIL bp_xfer%0d: got x=%0d y=%0d d=%h, expected x=%0d y=%0d", n, x, y,
                             pixel_data, n % H, n / H);
                end
                n++;
            end
            @(posedge clk); #1;
            if (frame_done) pulses++;
        end
        tests_run++;
        if ({stalled, 8'(n), 8'(pulses)} !== {1'b1, 8'd12, 8'd1}) begin
            tests_failed++;
            $display("FAIL bp_totals: got stalled=%b transfers=%0d pulses=%0d, expected 1/12/1", stalled, n, pulses);
        end
    endtask

    task automatic test_start_handling;
        int n;
        int done_e;
        int pulses;
        logic pulsed;
        logic seen;
        n = 0; done_e = -1; pulses = 0; pulsed = 1'b0; seen = 1'b0;
        gen_x = 9'd3;
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            if (n == 5 && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (pixel_valid && ready) begin
                tests_run++;
                if ({x, y, pixel_data} !== {9'(n % H), 8'(n / H), ((n % H) == 3) ? 16'hFFFF : 16'h0000}) begin
                    tests_failed++;
                    $display("FAIL midstart_xfer%0d: got x=%0d y=%0d d=%h, expected x=%0d y=%0d", n, x, y,
                             pixel_data, n % H, n / H);
                end
                n++;
            end
            @(posedge clk); #1;
            if (frame_done) begin
                pulses++;
                if (done_e < 0) done_e = e;
            end
        end
        start = 1'b0;
        tests_run++;
        if ({8'(n), 8'(done_e), 8'(pulses)} !== {8'd12, 8'd36, 8'd1}) begin
            tests_failed++;
            $display("FAIL midstart_totals: got transfers=%0d done_edge=%0d pulses=%0d, expected 12/36/1",
                     n, done_e, pulses);
        end

        // Hold start across DONE: retrigger on the first IDLE cycle
        start = 1'b1;
        @(posedge clk); #1;
        for (int e = 0; e < 60 && !seen; e++) begin
            @(posedge clk); #1;
            if (frame_done) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL held_start_done: got frame_done=%b within 60 cycles, expected 1", seen);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({busy, pixel_valid, frame_done, x, y} !== {3'b000, 9'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL held_start_idle: got b=%b v=%b fd=%b x=%0d y=%0d, expected idle at 0,0",
                     busy, pixel_valid, frame_done, x, y);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({busy, x, y} !== {1'b1, 9'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL held_start_retrig: got b=%b x=%0d y=%0d, expected b=1 x=0 y=0", busy, x, y);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 10 && !pixel_valid; i++) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if (pixel_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reach_send: got pixel_valid=%b, expected 1", pixel_valid);
        end
        #3;
        nrst = 1'b0;
        #1;
        tests_run++;
        if ({x, y, pixel_data, pixel_valid, busy, frame_done} !== {9'd0, 8'd0, 16'h0000, 3'b000}) begin
            tests_failed++;
            $display("FAIL async_reset: got x=%0d y=%0d d=%h v=%b b=%b fd=%b, expected all zero",
                     x, y, pixel_data, pixel_valid, busy, frame_done);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({x, y, pixel_valid, busy, frame_done} !== {9'd0, 8'd0, 3'b000}) begin
                tests_failed++;
                $display("FAIL post_reset_idle%0d: got x=%0d y=%0d v=%b b=%b fd=%b, expected idle",
                         i, x, y, pixel_valid, busy, frame_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_backpressure();
        test_start_handling();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
